// File: rtl/product_accumulator.sv
// Frame accumulator behind the 4x4 multiplier: sums LEN products per frame and
// presents the dot-product result on a valid/ready output port until it is taken.
module product_accumulator #(
  parameter int PW    = 8,
  parameter int LEN   = 4,
  parameter int CW    = 2,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [PW-1:0]    p,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CW-1:0]    elem_cnt
);

  localparam logic [0:0]    ST_ACC   = 1'b0;
  localparam logic [0:0]    ST_HOLD  = 1'b1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [0:0]       state_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_r;
  logic             sum_valid_r;
  logic [CW-1:0]    elem_cnt_r;
  logic             accept_s;
  logic [ACC_W-1:0] acc_next_s;

  // in_ready also drops while reset is held so nothing is taken during reset
  assign in_ready   = (state_r == ST_ACC) && rst_n;
  assign accept_s   = in_valid && in_ready;
  assign acc_next_s = acc_r + ACC_W'(p);

  assign sum       = sum_r;
  assign sum_valid = sum_valid_r;
  assign elem_cnt  = elem_cnt_r;

  // Frame state machine: clear beats both accept and result handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACC;
      acc_r       <= {ACC_W{1'b0}};
      sum_r       <= {ACC_W{1'b0}};
      sum_valid_r <= 1'b0;
      elem_cnt_r  <= {CW{1'b0}};
    end else if (clear) begin
      state_r     <= ST_ACC;
      acc_r       <= {ACC_W{1'b0}};
      sum_valid_r <= 1'b0;
      elem_cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s) begin
            if (elem_cnt_r == LAST_CNT) begin
              sum_r       <= acc_next_s;
              sum_valid_r <= 1'b1;
              acc_r       <= {ACC_W{1'b0}};
              elem_cnt_r  <= {CW{1'b0}};
              state_r     <= ST_HOLD;
            end else begin
              acc_r      <= acc_next_s;
              elem_cnt_r <= elem_cnt_r + ONE_CNT;
            end
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            sum_valid_r <= 1'b0;
            state_r     <= ST_ACC;
          end else begin
            sum_valid_r <= sum_valid_r;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          acc_r       <= {ACC_W{1'b0}};
          sum_valid_r <= 1'b0;
          elem_cnt_r  <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default LEN=4 instance plus a LEN=1 instance.
module tb_product_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] p;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] sum;
  logic       sum_valid;
  logic       sum_ready;
  logic [1:0] elem_cnt;

  logic       clear1;
  logic [7:0] p1;
  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] sum1;
  logic       sum_valid1;
  logic       sum_ready1;
  logic [0:0] elem_cnt1;

  int checks;
  int failures;

  product_accumulator #(.PW(8), .LEN(4), .CW(2), .ACC_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p(p), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .elem_cnt(elem_cnt)
  );

  product_accumulator #(.PW(8), .LEN(1), .CW(1), .ACC_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .p(p1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sum(sum1), .sum_valid(sum_valid1),
    .sum_ready(sum_ready1), .elem_cnt(elem_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       v;
    logic [7:0] pv;
    logic       sr;
    logic       e_rdy;
    logic       e_sv;
    logic [9:0] e_sum;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic clr, input logic v, input int pv, input logic sr,
                     input logic e_rdy, input logic e_sv, input int e_sum, input int e_cnt);
    vec_t r;
    r.clr = clr; r.v = v; r.pv = 8'(pv); r.sr = sr;
    r.e_rdy = e_rdy; r.e_sv = e_sv; r.e_sum = 10'(e_sum); r.e_cnt = 2'(e_cnt);
    vecs.push_back(r);
  endtask

  // drive one cycle of inputs, then compare outputs just after the edge
  task automatic apply(input vec_t r, input string tag);
    clear = r.clr; in_valid = r.v; p = r.pv; sum_ready = r.sr;
    @(posedge clk);
    #1;
    check({tag, ".in_ready"},  int'(in_ready),  int'(r.e_rdy));
    check({tag, ".sum_valid"}, int'(sum_valid), int'(r.e_sv));
    check({tag, ".sum"},       int'(sum),       int'(r.e_sum));
    check({tag, ".elem_cnt"},  int'(elem_cnt),  int'(r.e_cnt));
  endtask

  task automatic run_queue(input string tag);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  int'(in_ready),  0);
    check({tag, ".sum_valid"}, int'(sum_valid), 0);
    check({tag, ".sum"},       int'(sum),       0);
    check({tag, ".elem_cnt"},  int'(elem_cnt),  0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; clear = 1'b0; p = 8'd0; in_valid = 1'b0; sum_ready = 1'b0;
    clear1 = 1'b0; p1 = 8'd0; in_valid1 = 1'b0; sum_ready1 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    check("por.in_ready1", int'(in_ready1), 0);
    #20 rst_n = 1'b1;
    #1 check("rel.in_ready", int'(in_ready), 1);

    // basic frame 0+8+80+182, then 4x225
    add(0,1,  0,1, 1,0,  0,1);
    add(0,1,  8,1, 1,0,  0,2);
    add(0,1, 80,1, 1,0,  0,3);
    add(0,1,182,1, 0,1,270,0);
    add(0,0,  0,1, 1,0,270,0);
    add(0,1,225,1, 1,0,270,1);
    add(0,1,225,1, 1,0,270,2);
    add(0,1,225,1, 1,0,270,3);
    add(0,1,225,1, 0,1,900,0);
    // backpressure: p=7 offered for 5 HOLD cycles, must not be consumed
    for (int i = 0; i < 5; i++) add(0,1,7,0, 0,1,900,0);
    add(0,1,7,1, 1,0,900,0);
    add(0,1,7,1, 1,0,900,1);
    add(0,1,7,1, 1,0,900,2);
    add(0,1,7,1, 1,0,900,3);
    add(0,1,7,1, 0,1, 28,0);
    add(0,0,0,1, 1,0, 28,0);
    // clear after two accepts, then 1..4
    add(0,1,10,1, 1,0,28,1);
    add(0,1,20,1, 1,0,28,2);
    add(1,1,99,1, 1,0,28,0);
    add(0,1, 1,1, 1,0,28,1);
    add(0,1, 2,1, 1,0,28,2);
    add(0,1, 3,1, 1,0,28,3);
    add(0,1, 4,0, 0,1,10,0);
    // clear during HOLD keeps sum register
    add(1,0, 0,0, 1,0,10,0);
    // clear together with the 4th accept: no result
    add(0,1, 1,1, 1,0,10,1);
    add(0,1, 1,1, 1,0,10,2);
    add(0,1, 1,1, 1,0,10,3);
    add(1,1, 1,1, 1,0,10,0);
    run_queue("tbl");

    // async reset mid-frame
    add(0,1,50,1, 1,0,10,1);
    add(0,1,50,1, 1,0,10,2);
    run_queue("mf");
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mf");
    #12 rst_n = 1'b1;
    #1 check("rst_mf.rel_ready", int'(in_ready), 1);
    for (int i = 0; i < 3; i++) add(0,1,5,0, 1,0,0,i+1);
    add(0,1,5,0, 0,1,20,0);
    add(0,0,0,0, 0,1,20,0);
    run_queue("f5a");

    // async reset mid-HOLD
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_hold");
    #12 rst_n = 1'b1;
    add(0,0,0,1, 1,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,5,1, 1,0,0,i+1);
    add(0,1,5,1, 0,1,20,0);
    add(0,0,0,1, 1,0,20,0);
    run_queue("f5b");

    // LEN=1 instance: every accept goes straight to HOLD
    check("l1.ready0", int'(in_ready1), 1);
    in_valid1 = 1'b1; p1 = 8'd37; sum_ready1 = 1'b1;
    @(posedge clk); #1;
    check("l1.sv_a",  int'(sum_valid1), 1);
    check("l1.sum_a", int'(sum1), 37);
    check("l1.rdy_a", int'(in_ready1), 0);
    check("l1.cnt_a", int'(elem_cnt1), 0);
    p1 = 8'd50;
    @(posedge clk); #1;
    check("l1.sv_b",  int'(sum_valid1), 0);
    check("l1.rdy_b", int'(in_ready1), 1);
    check("l1.sum_b", int'(sum1), 37);
    @(posedge clk); #1;
    check("l1.sv_c",  int'(sum_valid1), 1);
    check("l1.sum_c", int'(sum1), 50);
    check("l1.rdy_c", int'(in_ready1), 0);
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    check("l1.rdy_d", int'(in_ready1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the 4x4 array multiplier: consumes its 8-bit product `p` under a valid/ready handshake and sums a fixed-length frame of LEN products into a dot-product result. The completed sum is presented on a valid/ready output port and held until accepted. Typical use: one clock domain, multiplier operands driven by an upstream sequencer, this block accumulating the multiplier output.

## Interface
- PW, 8, product width (multiplier output width)
- LEN, 4, products per frame, ≥1
- CW, 2, element counter width, ≥ max(1, ceil(log2 LEN))
- ACC_W, 10, accumulator/result width, ≥ PW + ceil(log2 LEN) (no overflow at defaults: 4×225=900)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: discard partial frame and any held result
- p  input  PW  product from multiplier, unsigned
- in_valid  input  1  p valid this cycle
- in_ready  output  1  block can accept p
- sum  output  ACC_W  frame result, unsigned
- sum_valid  output  1  sum valid
- sum_ready  input  1  consumer accepts sum
- elem_cnt  output  CW  products accepted in current frame

## Operation
- Two states: ACC (accepting products), HOLD (result pending).
- in_ready = (state==ACC) && rst_n; combinational, no dependency on in_valid.
- Accept = in_valid && in_ready.
- ACC, accept, elem_cnt < LEN-1: acc <= acc + p (zero-extended to ACC_W), elem_cnt++.
- ACC, accept, elem_cnt == LEN-1: sum <= acc + p, sum_valid <= 1, acc <= 0, elem_cnt <= 0, state -> HOLD.
- HOLD: in_ready=0; sum and sum_valid stable while sum_ready=0. On sum_ready: sum_valid <= 0, state -> ACC. sum retains last value after handoff.
- clear (any state) has priority over accept and sum_ready: acc <= 0, elem_cnt <= 0, sum_valid <= 0, state -> ACC; product presented that cycle is dropped; sum register unchanged.
- in_valid while in HOLD: not accepted; upstream must hold p (standard valid/ready: valid must not drop before accept).
- Arithmetic modulo 2^ACC_W; with legal ACC_W no wrap occurs.
- LEN=1: every accept goes straight to HOLD with sum = p.

## Timing
- Reset (rst_n=0, async): state=ACC, acc=0, elem_cnt=0, sum=0, sum_valid=0; in_ready=0 while rst_n low, 1 from first cycle after release.
- Latency: sum_valid rises on the clock edge of the LEN-th accept (visible next cycle).
- Throughput: LEN accepts + 1 HOLD cycle minimum per frame (one bubble even if sum_ready held high): frame period LEN+1 cycles.
- sum_ready sampled only in HOLD; ignored in ACC.
- Reset mid-frame or mid-HOLD: partial sum and pending result lost; no sum_valid pulse.
- Simultaneous clear and LEN-th accept: clear wins, no result produced.

## Test plan
- After reset, feed p=0,8,80,182 (products of 0×0,2×4,8×10,13×14) back-to-back with sum_ready=1 -> sum_valid one cycle after 4th accept, sum=270, in_ready low exactly one cycle, elem_cnt 0,1,2,3,0.
- Four products of 225 (15×15) -> sum=900, no overflow at ACC_W=10.
- Backpressure: complete frame, hold sum_ready=0 for 5 cycles with in_valid=1 -> sum stable, sum_valid=1, in_ready=0, no product consumed; raise sum_ready -> sum_valid drops next edge, next frame starts with elem_cnt=0.
- clear after 2 accepts (p=10,20), then frame 1,2,3,4 -> sum=10, partial 30 never appears; clear during HOLD -> sum_valid drops, sum register keeps value.
- Assert rst_n=0 asynchronously mid-frame and mid-HOLD -> all outputs to reset values without a clock edge; subsequent frame 5,5,5,5 -> sum=20.
- LEN=1, CW=1, ACC_W=8 instance: p=37 -> sum=37 next cycle, in_ready alternates 1,0 with sum_ready=1.
